// File: rtl/factorial_sum_seq_pkg.sv
// Shared definitions for the factorial-sum sequencer: default widths and FSM state encoding.
package factorial_sum_seq_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_N_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/factorial_sum_seq_rise_detect.sv
// Rising-edge detector for the slow clk_div square wave, sampled in the clk domain.
module factorial_sum_seq_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic q;

  // Resetting to 1 keeps a clk_div that is already high at reset release from looking like an edge.
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b1;
    else     q <= d;
  end

  assign pulse = d & ~q;

endmodule

// File: rtl/factorial_sum_seq.sv
// Sums 1!+..+n!, one term per rising edge of clk_div; start/done handshake with control logic.
// state   | meaning
// IDLE    | waiting for start; results from the last run held
// RUN     | accumulating one term per clk_div rising edge
// DONE    | one-cycle done pulse, then back to IDLE
module factorial_sum_seq
  import factorial_sum_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_WIDTH = DEF_N_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_div,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  output logic               busy,
  output logic               done,
  output logic [N_WIDTH-1:0] k,
  output logic [WIDTH-1:0]   fact,
  output logic [WIDTH-1:0]   sum,
  output logic               overflow
);

  state_t state, state_next;

  logic                       step;
  logic                       load;
  logic                       advance;
  logic [N_WIDTH-1:0]         n_r;
  logic [N_WIDTH-1:0]         k_inc;
  logic [WIDTH+N_WIDTH-1:0]   prod_full;
  logic [WIDTH:0]             sum_full;
  logic                       prod_ovf;

  factorial_sum_seq_rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .d     (clk_div),
    .pulse (step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // A step arriving in IDLE is simply not consumed, so start wins over a coincident edge.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (n == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (step) begin
          advance = 1'b1;
          if (k_inc == n_r) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign k_inc     = k + 1'b1;
  assign prod_full = {{N_WIDTH{1'b0}}, fact} * {{WIDTH{1'b0}}, k_inc};
  assign prod_ovf  = |prod_full[WIDTH+N_WIDTH-1:WIDTH];
  assign sum_full  = {1'b0, sum} + {1'b0, prod_full[WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      n_r      <= '0;
      k        <= '0;
      fact     <= WIDTH'(1);
      sum      <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      n_r      <= n;
      k        <= '0;
      fact     <= WIDTH'(1);
      sum      <= '0;
      overflow <= 1'b0;
    end else if (advance) begin
      k        <= k_inc;
      fact     <= prod_full[WIDTH-1:0];
      sum      <= sum_full[WIDTH-1:0];
      overflow <= overflow | prod_ovf | sum_full[WIDTH];
    end
  end

endmodule

// File: tb/tb_factorial_sum_seq.sv
// Directed-plus-random bench for factorial_sum_seq against an exact-arithmetic reference model.
module tb_factorial_sum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_div;
  logic        start;
  logic [3:0]  n;
  logic        busy;
  logic        done;
  logic [3:0]  k;
  logic [31:0] fact;
  logic [31:0] sum;
  logic        overflow;

  int tests = 0;
  int failed = 0;
  int done_cnt = 0;
  int dc_start = 0;

  factorial_sum_seq dut (
    .clk      (clk),
    .rst      (rst),
    .clk_div  (clk_div),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .k        (k),
    .fact     (fact),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exact factorial sum in 64-bit arithmetic; results are the low 32 bits, overflow when any
  // exact partial value no longer fits in 32 bits.
  task automatic model(input int nv, output logic [31:0] f, output logic [31:0] s,
                       output logic o);
    longint unsigned ef = 1;
    longint unsigned es = 0;
    o = 1'b0;
    for (int i = 1; i <= nv; i++) begin
      ef = ef * longint'(i);
      es = es + ef;
      if (ef > 64'hFFFF_FFFF || es > 64'hFFFF_FFFF) o = 1'b1;
    end
    f = ef[31:0];
    s = es[31:0];
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_k", k, 0);
    chk("rst_fact", fact, 1);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", overflow, 0);
  endtask

  task automatic start_seq(input int nv);
    dc_start = done_cnt;
    n = 4'(nv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 4'($urandom);
    chk("start_busy", busy, (nv != 0) ? 1 : 0);
  endtask

  task automatic give_edge(input int exp_k, input bit last);
    int lo = $urandom_range(1, 3);
    int hi = $urandom_range(1, 3);
    clk_div = 1'b0;
    repeat (lo) @(negedge clk);
    clk_div = 1'b1;
    @(negedge clk);
    chk("step_k", k, exp_k);
    if (last) chk("done_latency", done, 1);
    else      chk("busy_run", busy, 1);
    @(negedge clk);
    if (last) chk("done_one_cycle", done, 0);
    repeat (hi - 1) @(negedge clk);
  endtask

  task automatic run_edges(input int nv);
    for (int i = 1; i <= nv; i++) give_edge(i, i == nv);
  endtask

  task automatic finish_check(input int nv);
    logic [31:0] ef, es;
    logic        eo;
    model(nv, ef, es, eo);
    chk("fin_busy", busy, 0);
    chk("fin_k", k, nv);
    chk("fin_fact", fact, ef);
    chk("fin_sum", sum, es);
    chk("fin_ovf", overflow, eo);
    chk("fin_done_cnt", done_cnt, dc_start + 1);
  endtask

  task automatic run_full(input int nv);
    start_seq(nv);
    run_edges(nv);
    finish_check(nv);
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    clk_div = 1'b1;
    start = 1'b0;
    n = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // clk_div high across reset release must not produce a step
    repeat (2) @(negedge clk);
    start_seq(2);
    repeat (3) @(negedge clk);
    chk("no_spurious_k", k, 0);
    chk("no_spurious_busy", busy, 1);
    run_edges(2);
    finish_check(2);

    run_full(5);
    chk("n5_fact", fact, 120);
    chk("n5_sum", sum, 153);

    dc = done_cnt;
    n = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 0);
    @(negedge clk);
    chk("n0_done_end", done, 0);
    chk("n0_k", k, 0);
    chk("n0_fact", fact, 1);
    chk("n0_sum", sum, 0);
    chk("n0_done_cnt", done_cnt, dc + 1);

    run_full(12);
    chk("n12_sum", sum, 522956313);
    chk("n12_ovf", overflow, 0);
    run_full(13);
    chk("n13_ovf", overflow, 1);

    // start with a different n mid-run is ignored
    start_seq(5);
    give_edge(1, 0);
    give_edge(2, 0);
    n = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    give_edge(3, 0);
    give_edge(4, 0);
    give_edge(5, 1);
    finish_check(5);

    // reset mid-run, then restart
    start_seq(5);
    give_edge(1, 0);
    give_edge(2, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_no_done", done_cnt, dc_start);
    run_full(5);
    chk("restart_sum", sum, 153);

    // start coinciding with a clk_div edge: that edge is not a term
    clk_div = 1'b0;
    repeat (2) @(negedge clk);
    dc_start = done_cnt;
    n = 4'd3;
    start = 1'b1;
    clk_div = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("coincide_k", k, 0);
    chk("coincide_busy", busy, 1);
    repeat (2) @(negedge clk);
    run_edges(3);
    finish_check(3);

    for (int r = 0; r < 5; r++) run_full($urandom_range(1, 15));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
